mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, meaning the memory address width.
REQ-002 SHALL have parameter DW, default 16, meaning the memory data width.
REQ-003 SHALL have parameter LOCK_MAX, default 8, meaning the maximum number of consecutive cycles one master may hold the bus under lock.
REQ-004 SHALL have ports:
  clk  in  1  single clock; all state on rising edge.
  rst  in  1  reset, asynchronous, active-low.
  m0_req / m1_req  in  1  access request; m0 = CPU data port, m1 = secondary master (DMA/loader).
  m0_we / m1_we  in  1  write enable qualifying req.
  m0_lock / m1_lock  in  1  request to keep ownership next cycle.
  m0_addr / m1_addr  in  AW  access address.
  m0_wdata / m1_wdata  in  DW  write data.
  m0_gnt / m1_gnt  out  1  access accepted this cycle.
  m0_rvalid / m1_rvalid  out  1  read data valid; one-cycle pulse.
  m0_rdata / m1_rdata  out  DW  read data.
  mem_en  out  1  RAM access strobe.
  mem_we  out  1  RAM write strobe.
  mem_addr  out  AW  RAM address.
  mem_wdata  out  DW  RAM write data.
  mem_rdata  in  DW  RAM read data, valid one cycle after mem_en with mem_we=0.
  owner  out  2  01 = m0 owns, 10 = m1 owns, 00 = idle.

Function
REQ-005 SHALL implement FSM states IDLE, OWN0, OWN1, and a round-robin pointer rr (0 = m0 next preferred).
REQ-006 In IDLE, with only one req high, that master SHALL be granted combinationally in the same cycle.
REQ-007 In IDLE, with both req high, the master selected by rr SHALL be granted, and rr SHALL toggle to the other master at the clock edge.
REQ-008 A granted master SHALL have mem_en=1, and mem_we, mem_addr, and mem_wdata SHALL be muxed from that master in the same cycle; at most one gnt SHALL be high per cycle.
REQ-009 With no grant, mem_en=0 and mem_we=0 SHALL hold; mem_addr and mem_wdata SHALL hold their last values.
REQ-010 A granted read SHALL produce rvalid=1 to the same master exactly one cycle later, with rdata=mem_rdata; rdata of the non-returning master SHALL be 0.
REQ-011 A granted write SHALL produce no rvalid.
REQ-012 A grant with lock=1 SHALL move the FSM to OWNx, which SHALL persist while that master keeps req=1 and lock=1.
REQ-013 In OWNx, only master x SHALL be granted; the other master's gnt SHALL stay 0.
REQ-014 OWNx SHALL return to IDLE when master x drops req or lock, or when the lock counter reaches LOCK_MAX.
REQ-015 The lock counter SHALL count granted cycles in OWNx, clear on entry to IDLE, and saturate so that no wrap-around occurs.
REQ-016 On lock-timeout release, rr SHALL point to the other master, guaranteeing it the next IDLE arbitration.
REQ-017 A req deasserting in the same cycle as a timeout SHALL yield a single transition to IDLE, with no extra grant.
REQ-018 owner SHALL reflect the FSM state; in IDLE it SHALL show the combinational grant (00 if none).

Reset
REQ-019 When rst=0, the block SHALL set, asynchronously, FSM=IDLE, rr=0, lock counter=0, both rvalid=0, both rdata=0, and mem_addr=0 and mem_wdata=0.
REQ-020 During reset, all gnt, mem_en, and mem_we SHALL be 0 regardless of req.
REQ-021 A read granted in the cycle before reset assertion SHALL produce no rvalid.
REQ-022 The first arbitration after rst deasserts SHALL favour m0.

Configuration
REQ-023 With macro MEM_ARBITER_CPU_PRIORITY_EN defined, m0 SHALL always win IDLE arbitration and rr SHALL be unused; lock timeout SHALL still apply to m1, but m0 lock SHALL be unbounded.
REQ-024 Without the macro, round-robin per REQ-007 and the lock timeout for both masters SHALL apply.

Verification
REQ-025 Test: m0 write addr 0x0080 data 0x1234, then m0 read 0x0080 -> m0_rvalid high one cycle after the read grant, with m0_rdata=0x1234.
REQ-026 Test: both req held high for 4 cycles, no lock -> grants alternate m0,m1,m0,m1.
REQ-027 Test: m1 req+lock held for 12 cycles while m0 requests -> m1 granted exactly LOCK_MAX=8 cycles, then m0 granted on cycle 9.
REQ-028 Test: m0 read granted, then rst pulsed low mid-cycle -> no m0_rvalid, owner=00, all outputs at reset values.
REQ-029 Test: MEM_ARBITER_CPU_PRIORITY_EN defined, both req high for 4 cycles -> m0_gnt high on all 4 cycles, m1_gnt always 0.
REQ-030 Test: concurrent requests -> never two gnt high in the same cycle (checked every cycle).

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-master single-port RAM arbiter with bus lock, lock timeout
//               and round-robin; MEM_ARBITER_CPU_PRIORITY_EN gives m0 fixed win.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int                 c_cnt_w    = $clog2(LOCK_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_lock_max = c_cnt_w'(LOCK_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_OWN0 = 2'b01,
    S_OWN1 = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [c_cnt_w-1:0] w_cnt_inc;
  logic               w_req0;
  logic               w_req1;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_hold;
  logic               w_timeout;
  logic               w_pick1;
  logic               w_m0_bounded;
  logic [AW-1:0]      r_addr;
  logic [DW-1:0]      r_wdata;
  logic               r_rv0;
  logic               r_rv1;

  // Requests are masked while reset is held so nothing is granted.
  assign w_req0 = m0_req & rst;
  assign w_req1 = m1_req & rst;

`ifdef MEM_ARBITER_CPU_PRIORITY_EN
  assign w_pick1      = 1'b0;
  assign w_m0_bounded = 1'b0;
`else
  logic r_rr;

  assign w_pick1      = r_rr;
  assign w_m0_bounded = 1'b1;

  // After a contested grant or a timeout, prefer whoever did not win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr <= 1'b0;
    end else if (((r_state == S_IDLE) && w_req0 && w_req1) || w_timeout) begin
      r_rr <= w_gnt0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    owner       = 2'b00;
    w_state_nxt = S_IDLE;
    w_cnt_nxt   = '0;
    case (r_state)
      S_OWN0: begin
        w_gnt0 = w_req0;
        owner  = 2'b01;
      end
      S_OWN1: begin
        w_gnt1 = w_req1;
        owner  = 2'b10;
      end
      default: begin
        w_gnt0 = w_req0 & ~(w_req1 & w_pick1);
        w_gnt1 = w_req1 & ~w_gnt0;
        owner  = {w_gnt1, w_gnt0};
      end
    endcase
    // The counter includes the granting cycle, so ownership lasts LOCK_MAX cycles.
    w_cnt_inc = (r_cnt >= c_lock_max) ? r_cnt : r_cnt + c_cnt_w'(1);
    w_hold    = (w_gnt0 & m0_lock) | (w_gnt1 & m1_lock);
    w_timeout = w_hold & (w_gnt1 | w_m0_bounded) & (w_cnt_inc >= c_lock_max);
    if (w_hold && !w_timeout) begin
      w_state_nxt = w_gnt1 ? S_OWN1 : S_OWN0;
      w_cnt_nxt   = w_cnt_inc;
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign mem_en    = w_gnt0 | w_gnt1;
  assign mem_we    = (w_gnt0 & m0_we) | (w_gnt1 & m1_we);
  assign mem_addr  = w_gnt1 ? m1_addr  : (w_gnt0 ? m0_addr  : r_addr);
  assign mem_wdata = w_gnt1 ? m1_wdata : (w_gnt0 ? m0_wdata : r_wdata);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
      end
      r_rv0 <= w_gnt0 & ~m0_we;
      r_rv1 <= w_gnt1 & ~m1_we;
    end
  end

  assign m0_rvalid = r_rv0;
  assign m1_rvalid = r_rv1;
  assign m0_rdata  = r_rv0 ? mem_rdata : '0;
  assign m1_rdata  = r_rv1 ? mem_rdata : '0;

endmodule
`default_nettype wire
